// File: rtl/quad_pkg.sv
// Shared encodings for the quadrature decoder: AB phase codes, step direction
// type and the clockwise successor function.
package quad_pkg;

    localparam logic [1:0] AB_00 = 2'b00;
    localparam logic [1:0] AB_10 = 2'b10;
    localparam logic [1:0] AB_11 = 2'b11;
    localparam logic [1:0] AB_01 = 2'b01;

    // Legal transitions per detent before a step is counted
    localparam int PHASE_FULL = 4;

    typedef enum logic [1:0] {
        DIR_NONE    = 2'd0,
        DIR_UP      = 2'd1,
        DIR_DN      = 2'd2,
        DIR_ILLEGAL = 2'd3
    } dir_t;

    function automatic logic [1:0] cw_next(input logic [1:0] ab);
        case (ab)
            AB_00:   cw_next = AB_10;
            AB_10:   cw_next = AB_11;
            AB_11:   cw_next = AB_01;
            default: cw_next = AB_00;
        endcase
    endfunction

endpackage

// File: rtl/quad_step.sv
// Combinational transition classifier: previous and current AB pair -> direction.
module quad_step
    import quad_pkg::*;
(
    input  logic [1:0] prev_ab,
    input  logic [1:0] cur_ab,
    output dir_t       dir
);

    always_comb begin
        if (cur_ab == prev_ab) begin
            dir = DIR_NONE;
        end else if ((cur_ab ^ prev_ab) == 2'b11) begin
            dir = DIR_ILLEGAL;
        end else if (cur_ab == cw_next(prev_ab)) begin
            dir = DIR_UP;
        end else begin
            dir = DIR_DN;
        end
    end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature encoder position counter with optional detent accumulation,
// saturating or wrapping arithmetic, one-cycle step strobes and sticky error.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned STEP     = 1,
    parameter int unsigned INIT     = 0,
    parameter bit          SATURATE = 1'b1,
    parameter bit          DETENT   = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             a,
    input  logic             b,
    input  logic             clear,
    output logic [WIDTH-1:0] value,
    output logic             step_up,
    output logic             step_dn,
    output logic             error
);

    localparam logic signed [3:0] PH_POS    = 4'(PHASE_FULL);
    localparam logic signed [3:0] PH_NEG    = 4'(-PHASE_FULL);
    localparam logic [WIDTH:0]    STEP_X    = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH:0]    MAX_X     = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH-1:0]  INIT_VAL  = WIDTH'(INIT);

    logic [1:0]        cur_ab;
    logic [1:0]        prev_ab;
    logic              primed;
    logic signed [3:0] phase;
    logic signed [3:0] phase_sum;
    logic signed [3:0] phase_next;
    logic              count_up;
    logic              count_dn;
    logic              illegal;
    logic [WIDTH:0]    sum_up;
    logic [WIDTH:0]    diff_dn;
    logic [WIDTH-1:0]  value_up;
    logic [WIDTH-1:0]  value_dn;
    dir_t              dir;

    assign cur_ab = {a, b};

    quad_step u_step (
        .prev_ab (prev_ab),
        .cur_ab  (cur_ab),
        .dir     (dir)
    );

    // Detent mode counts only when a whole cycle of four same-direction edges
    // lands back on AB=00; any reversal walks the phase back toward zero.
    always_comb begin
        phase_sum  = phase;
        phase_next = phase;
        count_up   = 1'b0;
        count_dn   = 1'b0;
        illegal    = 1'b0;
        if (primed) begin
            case (dir)
                DIR_UP, DIR_DN: begin
                    if (DETENT) begin
                        phase_sum = (dir == DIR_UP) ? phase + 4'sd1 : phase - 4'sd1;
                        if (cur_ab == AB_00) begin
                            count_up   = (phase_sum == PH_POS);
                            count_dn   = (phase_sum == PH_NEG);
                            phase_next = '0;
                        end else begin
                            phase_next = phase_sum;
                        end
                    end else begin
                        count_up = (dir == DIR_UP);
                        count_dn = (dir == DIR_DN);
                    end
                end
                DIR_ILLEGAL: begin
                    illegal    = 1'b1;
                    phase_next = '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        sum_up   = {1'b0, value} + STEP_X;
        diff_dn  = {1'b0, value} - STEP_X;
        value_up = (SATURATE && (sum_up > MAX_X)) ? '1 : sum_up[WIDTH-1:0];
        value_dn = (SATURATE && diff_dn[WIDTH]) ? '0 : diff_dn[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev_ab <= '0;
            primed  <= 1'b0;
            phase   <= '0;
            value   <= INIT_VAL;
            step_up <= 1'b0;
            step_dn <= 1'b0;
            error   <= 1'b0;
        end else begin
            prev_ab <= cur_ab;
            primed  <= 1'b1;
            if (clear) begin
                phase   <= '0;
                value   <= INIT_VAL;
                step_up <= 1'b0;
                step_dn <= 1'b0;
                error   <= 1'b0;
            end else begin
                phase   <= phase_next;
                step_up <= count_up;
                step_dn <= count_dn;
                if (illegal) begin
                    error <= 1'b1;
                end
                if (count_up) begin
                    value <= value_up;
                end else if (count_dn) begin
                    value <= value_dn;
                end
            end
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: four parameter variants driven in parallel, a
// directed vector table, hand sequences and random stimulus vs a position model.
module tb_quad_decoder;

    logic             clk;
    logic             reset_n;
    logic             a;
    logic             b;
    logic             clear;
    logic [3:0][7:0]  dv;
    logic [3:0]       du;
    logic [3:0]       dd;
    logic [3:0]       de;

    int n_chk  = 0;
    int n_pass = 0;

    // Variant table: 0 detent/sat, 1 detent/wrap, 2 edge/sat/step8, 3 edge/wrap/step8
    int p_step [4] = '{1, 1, 8, 8};
    int p_init [4] = '{0, 0, 248, 248};
    int p_sat  [4] = '{1, 0, 1, 0};
    int p_det  [4] = '{1, 1, 0, 0};

    quad_decoder #(.WIDTH(8), .STEP(1), .INIT(0), .SATURATE(1), .DETENT(1)) u0 (
        .clk(clk), .reset_n(reset_n), .a(a), .b(b), .clear(clear),
        .value(dv[0]), .step_up(du[0]), .step_dn(dd[0]), .error(de[0]));
    quad_decoder #(.WIDTH(8), .STEP(1), .INIT(0), .SATURATE(0), .DETENT(1)) u1 (
        .clk(clk), .reset_n(reset_n), .a(a), .b(b), .clear(clear),
        .value(dv[1]), .step_up(du[1]), .step_dn(dd[1]), .error(de[1]));
    quad_decoder #(.WIDTH(8), .STEP(8), .INIT(248), .SATURATE(1), .DETENT(0)) u2 (
        .clk(clk), .reset_n(reset_n), .a(a), .b(b), .clear(clear),
        .value(dv[2]), .step_up(du[2]), .step_dn(dd[2]), .error(de[2]));
    quad_decoder #(.WIDTH(8), .STEP(8), .INIT(248), .SATURATE(0), .DETENT(0)) u3 (
        .clk(clk), .reset_n(reset_n), .a(a), .b(b), .clear(clear),
        .value(dv[3]), .step_up(du[3]), .step_dn(dd[3]), .error(de[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: encoder position as a number 0..3 around the CW cycle
    int m_val [4];
    int m_acc [4];
    bit m_up  [4];
    bit m_dn  [4];
    bit m_err [4];
    bit m_primed;
    int m_prev_pos;

    function automatic int pos_of(input bit pa, input bit pb);
        if (pa) return pb ? 2 : 1;
        return pb ? 3 : 0;
    endfunction

    task automatic model_edge(input bit na, input bit nb, input bit clr, input bit rn);
        int p;
        int d;
        int s;
        p = pos_of(na, nb);
        d = (p - m_prev_pos + 4) % 4;
        for (int i = 0; i < 4; i++) begin
            m_up[i] = 1'b0;
            m_dn[i] = 1'b0;
            if (!rn) begin
                m_val[i] = p_init[i];
                m_acc[i] = 0;
                m_err[i] = 1'b0;
            end else if (clr) begin
                m_val[i] = p_init[i];
                m_acc[i] = 0;
                m_err[i] = 1'b0;
            end else if (m_primed && d == 2) begin
                m_err[i] = 1'b1;
                m_acc[i] = 0;
            end else if (m_primed && d != 0) begin
                s = (d == 1) ? 1 : -1;
                if (p_det[i] != 0) begin
                    m_acc[i] += s;
                    if (p == 0) begin
                        m_up[i]  = (m_acc[i] == 4);
                        m_dn[i]  = (m_acc[i] == -4);
                        m_acc[i] = 0;
                    end
                end else begin
                    m_up[i] = (s > 0);
                    m_dn[i] = (s < 0);
                end
                if (m_up[i])
                    m_val[i] = (p_sat[i] != 0) ? ((m_val[i] + p_step[i] > 255) ? 255 : m_val[i] + p_step[i])
                                               : (m_val[i] + p_step[i]) % 256;
                if (m_dn[i])
                    m_val[i] = (p_sat[i] != 0) ? ((m_val[i] - p_step[i] < 0) ? 0 : m_val[i] - p_step[i])
                                               : (m_val[i] - p_step[i] + 256) % 256;
            end
        end
        if (!rn) begin
            m_primed = 1'b0;
        end else begin
            m_primed   = 1'b1;
            m_prev_pos = p;
        end
    endtask

    task automatic check(input string name, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    task automatic tick(input bit na, input bit nb, input bit clr, input bit rn);
        @(negedge clk);
        a       = na;
        b       = nb;
        clear   = clr;
        reset_n = rn;
        model_edge(na, nb, clr, rn);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("model_value_u%0d t=%0t", i, $time), int'(dv[i]), m_val[i]);
            check($sformatf("model_up_dn_err_u%0d t=%0t", i, $time),
                  int'({du[i], dd[i], de[i]}), int'({m_up[i], m_dn[i], m_err[i]}));
        end
    endtask

    typedef struct {
        bit a;
        bit b;
        bit clr;
        bit rn;
        int ev;
        bit eu;
        bit ed;
        bit ee;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit va, input bit vb, input bit vc, input bit vr,
                       input int ev, input bit eu, input bit ed, input bit ee);
        vec_t v;
        v.a = va; v.b = vb; v.clr = vc; v.rn = vr;
        v.ev = ev; v.eu = eu; v.ed = ed; v.ee = ee;
        tbl.push_back(v);
    endtask

    initial begin
        int curp;
        int r;
        int m;
        int d;
        a = 1'b0; b = 1'b0; clear = 1'b0; reset_n = 1'b0;
        m_primed = 1'b0;
        m_prev_pos = 0;

        // Expected values for variant 0 (detent, saturating, step 1, init 0)
        add(0,0,0,0, 0,0,0,0);
        add(0,0,0,1, 0,0,0,0);
        add(1,0,0,1, 0,0,0,0); add(1,1,0,1, 0,0,0,0); add(0,1,0,1, 0,0,0,0);
        add(0,0,0,1, 1,1,0,0);
        add(0,0,0,1, 1,0,0,0);
        for (int k = 2; k <= 4; k++) begin
            add(1,0,0,1, k-1,0,0,0); add(1,1,0,1, k-1,0,0,0); add(0,1,0,1, k-1,0,0,0);
            add(0,0,0,1, k,1,0,0);
        end
        add(1,0,0,1, 4,0,0,0); add(1,1,0,1, 4,0,0,0); add(1,0,0,1, 4,0,0,0); add(0,0,0,1, 4,0,0,0);
        add(0,1,0,1, 4,0,0,0); add(1,1,0,1, 4,0,0,0); add(1,0,0,1, 4,0,0,0); add(0,0,0,1, 3,0,1,0);
        add(1,1,0,1, 3,0,0,1); add(1,1,0,1, 3,0,0,1);
        add(1,1,1,1, 0,0,0,0); add(1,1,0,1, 0,0,0,0);
        add(0,1,0,1, 0,0,0,0); add(0,0,0,1, 0,0,0,0);
        add(1,0,0,1, 0,0,0,0); add(1,1,0,1, 0,0,0,0);
        add(1,1,0,0, 0,0,0,0); add(0,1,0,1, 0,0,0,0); add(0,0,0,1, 0,0,0,0);
        add(1,1,0,0, 0,0,0,0); add(1,1,0,1, 0,0,0,0); add(1,1,0,1, 0,0,0,0);
        add(0,1,0,1, 0,0,0,0); add(0,0,0,1, 0,0,0,0);
        add(0,1,0,1, 0,0,0,0); add(1,1,0,1, 0,0,0,0); add(1,0,0,1, 0,0,0,0); add(0,0,0,1, 0,0,1,0);

        foreach (tbl[i]) begin
            tick(tbl[i].a, tbl[i].b, tbl[i].clr, tbl[i].rn);
            check($sformatf("vec%0d_value", i), int'(dv[0]), tbl[i].ev);
            check($sformatf("vec%0d_up_dn_err", i), int'({du[0], dd[0], de[0]}),
                  int'({tbl[i].eu, tbl[i].ed, tbl[i].ee}));
        end
        check("ccw_from_zero_wrap_u1", int'(dv[1]), 255);

        // Edge-counting variants starting at 248 with step 8
        tick(0,0,0,0);
        tick(0,0,0,1);
        check("init_u2", int'(dv[2]), 248);
        tick(1,0,0,1);
        check("clamp_first_u2", int'(dv[2]), 255);
        check("clamp_first_strobe_u2", int'(du[2]), 1);
        check("wrap_first_u3", int'(dv[3]), 0);
        tick(1,1,0,1);
        check("clamp_second_u2", int'(dv[2]), 255);
        check("clamp_second_strobe_u2", int'(du[2]), 1);
        check("wrap_second_u3", int'(dv[3]), 8);
        check("wrap_second_strobe_u3", int'(du[3]), 1);
        tick(1,1,0,1);
        check("strobe_drops_u2", int'(du[2]), 0);

        // Random walk, mostly legal edges, occasional jump, clear and reset
        curp = 2;
        for (int n = 0; n < 800; n++) begin
            r = $urandom_range(0, 63);
            m = $urandom_range(0, 19);
            d = (m < 6) ? 0 : (m < 12) ? 1 : (m < 19) ? 3 : 2;
            curp = (curp + d) % 4;
            tick(curp == 1 || curp == 2, curp == 2 || curp == 3, r == 1, r != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
